simple_proc_mc: RTL
===================

# simple_proc_mc

Parametrised multi-cycle successor to the team's 8-bit processor.

- It holds a generic register file and executes one instruction per `run` handshake, selected by a 3-bit opcode plus two register fields.
- It adds:
  - logic ops
  - an explicit output instruction
  - zero and carry flags
  - a `busy`/`done` handshake
- It sits between the instruction source (switches or sequencer) and the data bus.

## Interface
Parameters:
- `DATA_W`, default 8: datapath and register width.
- `NREG`, default 8: number of registers; must be a power of 2 and at least 2. `RA = log2(NREG)`.

Ports:
- `clock`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `run`, input, 1: start request; sampled only in IDLE.
- `func`, input, 3+2·RA: `{opcode[2:0], Rx[RA-1:0], Ry[RA-1:0]}`.
- `dataIn`, input, DATA_W: immediate operand for MVI.
- `dataOut`, output, DATA_W: registered output bus, written only by OUT.
- `busy`, output, 1: high while an instruction is in flight.
- `done`, output, 1: one-cycle completion pulse.
- `zf`, output, 1: zero flag, registered.
- `cf`, output, 1: carry/borrow flag, registered.

## Operation
Opcodes:
- 000 MVI: `R[Rx] <= dataIn`.
- 001 MV: `R[Rx] <= R[Ry]`.
- 010 ADD: `R[Rx] <= R[Rx] + R[Ry]`.
- 011 SUB: `R[Rx] <= R[Rx] − R[Ry]`.
- 100 AND: `R[Rx] <= R[Rx] & R[Ry]`.
- 101 OR: `R[Rx] <= R[Rx] | R[Ry]`.
- 110 OUT: `dataOut <= R[Rx]`; Ry is ignored and no register is written.
- 111 NOP: no state change except the handshake.

State machine:
- States: IDLE, EXEC, WB.
- IDLE, `run`=1 at an edge: capture `IR <= func`, `A <= R[Rx]`, `B <= R[Ry]`, `D <= dataIn`.
  - ALU ops (010–101) go to EXEC.
  - All other opcodes go to WB.
- IDLE, `run`=0: stay in IDLE.
- EXEC: `G <=` ALU(A, B) at full DATA_W+1 width; go to WB.
- WB: perform the opcode's write (register, `dataOut`, flags); set `done <= 1`; go to IDLE.

Arithmetic and flag rules:
- Results are truncated mod 2^DATA_W.
- ADD: `cf` = carry-out bit DATA_W.
- SUB: `cf` = borrow, i.e. 1 iff `R[Rx] < R[Ry]` unsigned.
- AND/OR: `cf` <= 0.
- `zf` = 1 iff the truncated result is 0.
- Flags change only on ADD/SUB/AND/OR; MVI/MV/OUT/NOP leave them unchanged.

Boundary conditions:
- Rx == Ry is legal. Operands are captured before write-back, so:
  - ADD R,R doubles.
  - SUB R,R gives 0 with `zf`=1, `cf`=0.
- `func` and `dataIn` are sampled only at the accepting edge; later changes are ignored.
- `run` while `busy`=1 is ignored, not queued.

## Timing
Reset:
- `reset`=1 at an edge forces:
  - state IDLE
  - all `R[i]` = 0
  - `dataOut` = 0
  - `zf` = `cf` = 0
  - `done` = 0, `busy` = 0
- `reset` dominates `run`.
- Reset in EXEC or WB aborts the instruction: no register, `dataOut`, or flag write, and no `done` pulse.

Handshake:
- `busy` is combinational from state: high in EXEC and WB, low in IDLE.
- `done` is registered: high for exactly the one cycle after the WB edge (state is IDLE in that cycle).
- `run` may be asserted in the same cycle `done` is high, giving back-to-back issue.

Latency, counted from the accepting edge E0 to the edge at which the result is visible:
- ALU ops: 3 edges (E0, EXEC, WB); `done` is high in cycle E3.
- MVI/MV/OUT/NOP: 2 edges; `done` is high in cycle E2.
- Peak throughput: one ALU op per 3 cycles, one move per 2 cycles.

## Test plan
- After reset, check all outputs are 0. Then MVI R3 with `dataIn`=0xA5, followed by OUT R3 → `dataOut`=0xA5 exactly 2 edges after the OUT accept, with one `done` pulse per instruction.
- MVI R1=0xFF, MVI R2=0x01, ADD R1,R2 → R1=0x00, `zf`=1, `cf`=1. `done` is high 3 cycles after the ADD accept; `busy` is high for exactly 2 cycles.
- MVI R4=0x05, MVI R5=0x07, SUB R4,R5, OUT R4 → `dataOut`=0xFE, `cf`=1, `zf`=0. Then SUB R5,R5 → R5=0, `zf`=1, `cf`=0.
- Assert `run` with ADD while `busy`, and change `func`/`dataIn` mid-instruction → the extra request is ignored and the result uses only the originally captured operands.
- Assert `reset` in EXEC of ADD R1,R2 (R1=0x10) → R1=0, no `done` pulse, and the next MVI executes normally.
- Instantiate DATA_W=16, NREG=16 (func width 11): MVI R15=0x8000, ADD R15,R15 → R15=0x0000, `cf`=1, `zf`=1. Then MV R0,R15 and OUT R0 → `dataOut`=0x0000.

Source files
------------

// File: rtl/simple_proc_mc.sv
// -----------------------------------------------------------------------------
// simple_proc_mc
//
// Parametrised multi-cycle processor core. Holds an NREG x DATA_W register
// file and executes one instruction per run handshake. Move-class instructions
// (MVI, MV, OUT, NOP) take two edges (IDLE -> WB -> IDLE). ALU instructions
// (ADD, SUB, AND, OR) take three edges (IDLE -> EXEC -> WB -> IDLE).
//
// Ports:
//   clock    : single clock, all state changes on the rising edge
//   reset    : synchronous, active-high; aborts any instruction in flight
//   run      : start request, sampled only in IDLE
//   func     : {opcode[2:0], Rx[RA-1:0], Ry[RA-1:0]}, sampled at the accepting edge
//   dataIn   : immediate operand for MVI, sampled at the accepting edge
//   dataOut  : registered output bus, written only by OUT
//   busy     : high while an instruction is in flight (EXEC or WB)
//   done     : one-cycle completion pulse, in the cycle after the WB edge
//   zf, cf   : registered zero and carry/borrow flags (ALU ops only)
// -----------------------------------------------------------------------------
module simple_proc_mc #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      run,
    input  logic [2+2*$clog2(NREG):0] func,
    input  logic [DATA_W-1:0]         dataIn,
    output logic [DATA_W-1:0]         dataOut,
    output logic                      busy,
    output logic                      done,
    output logic                      zf,
    output logic                      cf
);

    localparam int RA     = $clog2(NREG);
    localparam int FUNC_W = 3 + 2 * RA;

    typedef enum logic [2:0] {
        OP_MVI = 3'b000,
        OP_MV  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_OUT = 3'b110,
        OP_NOP = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [FUNC_W-1:0]   r_ir;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_d;
    logic [DATA_W:0]     r_g;
    logic [DATA_W-1:0]   r_regs [NREG];
    logic [DATA_W-1:0]   r_dout;
    logic                r_zf;
    logic                r_cf;
    logic                r_done;

    // Fields of the incoming instruction (used only at the accepting edge).
    opcode_t             w_in_op;
    logic [RA-1:0]       w_in_rx;
    logic [RA-1:0]       w_in_ry;

    // Fields of the captured instruction (used in EXEC and WB).
    opcode_t             w_ir_op;
    logic [RA-1:0]       w_ir_rx;

    logic                w_in_is_alu;
    logic [DATA_W:0]     w_alu;

    assign w_in_op     = opcode_t'(func[FUNC_W-1 -: 3]);
    assign w_in_rx     = func[2*RA-1 -: RA];
    assign w_in_ry     = func[RA-1:0];

    assign w_ir_op     = opcode_t'(r_ir[FUNC_W-1 -: 3]);
    assign w_ir_rx     = r_ir[2*RA-1 -: RA];

    assign w_in_is_alu = w_in_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning the default before the case keeps every path
        // driven, so no latch is inferred when a branch leaves it untouched.
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next_state = w_in_is_alu ? S_EXEC : S_WB;
                end
            end
            S_EXEC:  w_next_state = S_WB;
            S_WB:    w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // ALU: evaluated one bit wider than the datapath. For SUB the extra bit
    // of the zero-extended difference is exactly the unsigned borrow.
    // ---------------------------------------------------------------------
    always_comb begin
        w_alu = '0;
        case (w_ir_op)
            OP_ADD:  w_alu = {1'b0, r_a} + {1'b0, r_b};
            OP_SUB:  w_alu = {1'b0, r_a} - {1'b0, r_b};
            OP_AND:  w_alu = {1'b0, r_a & r_b};
            OP_OR:   w_alu = {1'b0, r_a | r_b};
            default: w_alu = '0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath. Operands are captured at the accepting edge, so Rx == Ry
    // reads the pre-write-back value for both sides.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the register file is architecturally visible after reset
            // (all R[i] read as 0), so it is cleared explicitly rather than
            // left to power-up contents.
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_ir   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_d    <= '0;
            r_g    <= '0;
            r_dout <= '0;
            r_zf   <= 1'b0;
            r_cf   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples values from before this edge.
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_ir <= func;
                        r_a  <= r_regs[w_in_rx];
                        r_b  <= r_regs[w_in_ry];
                        r_d  <= dataIn;
                    end
                end
                S_EXEC: begin
                    r_g <= w_alu;
                end
                S_WB: begin
                    r_done <= 1'b1;
                    case (w_ir_op)
                        OP_MVI: r_regs[w_ir_rx] <= r_d;
                        OP_MV:  r_regs[w_ir_rx] <= r_b;
                        OP_ADD, OP_SUB: begin
                            r_regs[w_ir_rx] <= r_g[DATA_W-1:0];
                            r_zf            <= (r_g[DATA_W-1:0] == '0);
                            r_cf            <= r_g[DATA_W];
                        end
                        OP_AND, OP_OR: begin
                            r_regs[w_ir_rx] <= r_g[DATA_W-1:0];
                            r_zf            <= (r_g[DATA_W-1:0] == '0);
                            r_cf            <= 1'b0;
                        end
                        OP_OUT: r_dout <= r_a;
                        default: begin
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign dataOut = r_dout;
    assign zf      = r_zf;
    assign cf      = r_cf;

endmodule
